alus: RTL and testbench
=======================

# alus

Arithmetic-logic-shift unit with registered inputs and a registered 6-bit output. It takes two 3-bit operands and a 3-bit opcode and performs AND/XOR (bitwise or reduction), add, multiply, shift or rotate. Invalid operation codes force the output to zero and blink a 16-bit LED bank. It sits as a leaf datapath block in a board-level demo, with `leds` driving user LEDs.

## Interface
Parameters:
- INPUT_PRIORITY, "A": operand priority when both bypass flags, or both reduction flags, are set. "A" selects A; "B" selects B.
- FULL_ADDER, "ON": "ON" adds cin into the sum; "OFF" ignores cin.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cin  in  1  carry-in for add (used only when FULL_ADDER="ON").
- serial_in  in  1  bit shifted in for opcode 4.
- A  in  3  operand A, unsigned.
- B  in  3  operand B, unsigned.
- opcode  in  3  operation select.
- red_op_A  in  1  use reduction of A for opcodes 0/1.
- red_op_B  in  1  use reduction of B for opcodes 0/1.
- bypass_A  in  1  pass A directly to out.
- bypass_B  in  1  pass B directly to out.
- direction  in  1  shift/rotate direction: 1 = left, 0 = right.
- leds  out  16  invalid-operation indicator.
- out  out  6  registered result.

## Operation
- All inputs are captured into an input register every clock. All evaluation below uses the registered copies.
- An operation is invalid when opcode is 6 or 7, or when (red_op_A | red_op_B) is set and opcode is 2–5.
- The new `out` value is chosen in priority order; results are zero-extended to 6 bits:
  1. Bypass: if either bypass flag is set, out = the prioritized operand. With INPUT_PRIORITY="A", A wins when both are set. Bypass overrides invalid.
  2. Invalid: out = 0.
  3. opcode 0: red_op → &A or &B, using the priority operand when both flags are set; otherwise A & B.
  4. opcode 1: same selection as opcode 0 with ^ (XOR).
  5. opcode 2: A + B + cin; cin is dropped when FULL_ADDER="OFF". Maximum 15.
  6. opcode 3: A * B. Maximum 49; fits in 6 bits.
  7. opcode 4, shift:
     - direction=1: out = {out[4:0], serial_in}.
     - direction=0: out = {serial_in, out[5:1]}.
  8. opcode 5, rotate:
     - direction=1: out = {out[4:0], out[5]}.
     - direction=0: out = {out[0], out[5:1]}.
- Shift and rotate act on the current `out` register and repeat every clock while the opcode is held.
- leds:
  - When the registered inputs are invalid, leds = ~leds every clock (blinks 0x0000/0xFFFF).
  - Otherwise leds = 0.
  - leds blink even when a bypass drives `out`.

## Timing
- Reset value: out = 0, leds = 0, and all input registers = 0. Reset acts immediately and asynchronously; a reset mid-shift clears the state.
- Latency is 2 clocks: an input applied before rising edge N appears on `out` after rising edge N+1.
- `out` updates every cycle with no handshake. A held shift or rotate opcode advances `out` by one position per cycle.
- Changing inputs mid-sequence takes effect 2 edges later. No stall or hold exists.

## Configuration
- ALUS_LED_BLINK_EN:
  - Defined: leds blink on invalid operations as described above.
  - Undefined: leds tied to 0 and the blink register is removed.
  - `out` behaviour is identical in both cases.

## Test plan
- Reset, then A=5, B=3, cin=1, opcode=2, no flags: after 2 edges, out=9. With FULL_ADDER="OFF", out=8.
- A=7, B=7, opcode=3: out=49. Then bypass_A=bypass_B=1 with A=2, B=6, opcode=7: out=2, and leds toggle 0xFFFF/0x0000 each cycle.
- out=9 (001001), then opcode=4, direction=1, serial_in=1 held: out=010011, then 100111 on consecutive cycles. With opcode=5, direction=0 from 001001: out=100100, then 010010.
- red_op_A=1, A=3'b111, opcode=0: out=1. Same with opcode=1: out=1. red_op_B=1, B=3'b011, opcode=1: out=0.
- opcode=6, or red_op_A=1 with opcode=3, no bypass: out=0 and leds blink. Switching to opcode=0 with no flags: leds=0 within 2 edges.
- Assert rst mid-rotate: out=0 and leds=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alus.sv
// rtl/alus.sv - registered 3-bit ALU/shift unit with a 6-bit result and invalid-op LED blink
// Optional feature macro: ALUS_LED_BLINK_EN (leds blink on invalid ops; tied to 0 when undefined).
module alus #(
    parameter INPUT_PRIORITY = "A",
    parameter FULL_ADDER     = "ON"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cin,
    input  logic        serial_in,
    input  logic [2:0]  A,
    input  logic [2:0]  B,
    input  logic [2:0]  opcode,
    input  logic        red_op_A,
    input  logic        red_op_B,
    input  logic        bypass_A,
    input  logic        bypass_B,
    input  logic        direction,
    output logic [15:0] leds,
    output logic [5:0]  out
);
    localparam bit PRIO_B  = (INPUT_PRIORITY == "B");
    localparam bit USE_CIN = (FULL_ADDER == "ON");

    logic [2:0] a_r, b_r, op_r;
    logic       cin_r, sin_r, red_a_r, red_b_r, byp_a_r, byp_b_r, dir_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            op_r    <= '0;
            cin_r   <= 1'b0;
            sin_r   <= 1'b0;
            red_a_r <= 1'b0;
            red_b_r <= 1'b0;
            byp_a_r <= 1'b0;
            byp_b_r <= 1'b0;
            dir_r   <= 1'b0;
        end else begin
            a_r     <= A;
            b_r     <= B;
            op_r    <= opcode;
            cin_r   <= cin;
            sin_r   <= serial_in;
            red_a_r <= red_op_A;
            red_b_r <= red_op_B;
            byp_a_r <= bypass_A;
            byp_b_r <= bypass_B;
            dir_r   <= direction;
        end
    end

    logic       red_any, invalid, red_use_b, byp_use_b;
    logic [2:0] red_opnd, byp_opnd;
    logic [3:0] sum;
    logic [5:0] next_out;

    always_comb begin
        red_any   = red_a_r | red_b_r;
        invalid   = (op_r >= 3'd6) || (red_any && (op_r >= 3'd2) && (op_r <= 3'd5));
        // With both flags set the priority parameter decides which operand is used
        red_use_b = (red_a_r && red_b_r) ? PRIO_B : red_b_r;
        byp_use_b = (byp_a_r && byp_b_r) ? PRIO_B : byp_b_r;
        red_opnd  = red_use_b ? b_r : a_r;
        byp_opnd  = byp_use_b ? b_r : a_r;
        sum       = {1'b0, a_r} + {1'b0, b_r} + {3'b000, cin_r & USE_CIN};
        next_out  = '0;
        if (byp_a_r || byp_b_r) begin
            next_out = {3'b000, byp_opnd};
        end else if (!invalid) begin
            case (op_r)
                3'd0: next_out = red_any ? {5'b0, &red_opnd} : {3'b000, a_r & b_r};
                3'd1: next_out = red_any ? {5'b0, ^red_opnd} : {3'b000, a_r ^ b_r};
                3'd2: next_out = {2'b00, sum};
                3'd3: next_out = {3'b000, a_r} * {3'b000, b_r};
                3'd4: next_out = dir_r ? {out[4:0], sin_r} : {sin_r, out[5:1]};
                3'd5: next_out = dir_r ? {out[4:0], out[5]} : {out[0], out[5:1]};
                default: next_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= next_out;
        end
    end

`ifdef ALUS_LED_BLINK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds <= '0;
        end else if (invalid) begin
            leds <= ~leds;
        end else begin
            leds <= '0;
        end
    end
`else
    assign leds = '0;
`endif

endmodule

// File: tb/tb_alus.sv
// tb/tb_alus.sv - directed self-checking bench for alus with a cycle model
module tb_alus;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cin = 1'b0, serial_in = 1'b0, direction = 1'b0;
    logic [2:0]  A = '0, B = '0, opcode = '0;
    logic        red_op_A = 1'b0, red_op_B = 1'b0, bypass_A = 1'b0, bypass_B = 1'b0;
    logic [15:0] leds, leds_alt;
    logic [5:0]  out, out_alt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alus u_dut (
        .clk(clk), .rst(rst), .cin(cin), .serial_in(serial_in), .A(A), .B(B),
        .opcode(opcode), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .bypass_A(bypass_A), .bypass_B(bypass_B), .direction(direction),
        .leds(leds), .out(out)
    );

    alus #(.INPUT_PRIORITY("B"), .FULL_ADDER("OFF")) u_alt (
        .clk(clk), .rst(rst), .cin(cin), .serial_in(serial_in), .A(A), .B(B),
        .opcode(opcode), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .bypass_A(bypass_A), .bypass_B(bypass_B), .direction(direction),
        .leds(leds_alt), .out(out_alt)
    );

    typedef struct packed {
        logic [2:0] a, b, op;
        logic cin, sin, ra, rb, ba, bb, dir;
    } inrec_t;

    inrec_t     in_m;
    logic [5:0] out_m, out_m2;
    logic [15:0] leds_m;

    function automatic bit is_invalid(input inrec_t r);
        return (r.op == 6 || r.op == 7) || ((r.ra || r.rb) && r.op >= 2 && r.op <= 5);
    endfunction

    function automatic logic [5:0] model_out(input inrec_t r, input logic [5:0] prev,
                                             input bit prio_b, input bit full);
        int x, s;
        logic [2:0] opnd;
        if (r.ba || r.bb) begin
            opnd = (r.ba && r.bb) ? (prio_b ? r.b : r.a) : (r.ba ? r.a : r.b);
            return {3'b000, opnd};
        end
        if (is_invalid(r)) return 6'd0;
        opnd = (r.ra && r.rb) ? (prio_b ? r.b : r.a) : (r.ra ? r.a : r.b);
        x = int'(prev);
        case (r.op)
            0: return (r.ra || r.rb) ? ((opnd == 3'b111) ? 6'd1 : 6'd0) : {3'b000, r.a & r.b};
            1: return (r.ra || r.rb) ? 6'((opnd[0] + opnd[1] + opnd[2]) % 2) : {3'b000, r.a ^ r.b};
            2: begin
                s = int'(r.a) + int'(r.b) + (full ? int'(r.cin) : 0);
                return 6'(s);
            end
            3: return 6'(int'(r.a) * int'(r.b));
            4: return r.dir ? 6'((x * 2) % 64 + int'(r.sin)) : 6'(x / 2 + 32 * int'(r.sin));
            default: return r.dir ? 6'((x * 2) % 64 + x / 32) : 6'(x / 2 + 32 * (x % 2));
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            in_m   <= '0;
            out_m  <= '0;
            out_m2 <= '0;
            leds_m <= '0;
        end else begin
            out_m  <= model_out(in_m, out_m, 1'b0, 1'b1);
            out_m2 <= model_out(in_m, out_m2, 1'b1, 1'b0);
`ifdef ALUS_LED_BLINK_EN
            leds_m <= is_invalid(in_m) ? (16'hFFFF - leds_m) : 16'h0000;
`else
            leds_m <= 16'h0000;
`endif
            in_m   <= {A, B, opcode, cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction};
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("model_out", int'(out), int'(out_m));
            check("model_out_alt", int'(out_alt), int'(out_m2));
            check("model_leds", int'(leds), int'(leds_m));
            check("model_leds_alt", int'(leds_alt), int'(leds_m));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic load_nine();
        red_op_A = 0; red_op_B = 0; bypass_A = 0; bypass_B = 0;
        A = 3'd5; B = 3'd3; cin = 1; opcode = 3'd2;
        tick(2);
        check("add_5_3_1", int'(out), 9);
    endtask

    int blink_hi;

    initial begin
`ifdef ALUS_LED_BLINK_EN
        blink_hi = 16'hFFFF;
`else
        blink_hi = 0;
`endif
        repeat (2) @(negedge clk);
        check("reset_out", int'(out), 0);
        check("reset_leds", int'(leds), 0);
        rst = 0;

        load_nine();
        check("add_no_cin", int'(out_alt), 8);

        A = 3'd7; B = 3'd7; opcode = 3'd3; tick(2);
        check("mul_7_7", int'(out), 49);

        bypass_A = 1; bypass_B = 1; A = 3'd2; B = 3'd6; opcode = 3'd7; tick(2);
        check("bypass_prio_a", int'(out), 2);
        check("bypass_prio_b", int'(out_alt), 6);
        check("bypass_leds_on", int'(leds), blink_hi);
        tick(1);
        check("bypass_leds_off", int'(leds), 0);
        check("bypass_hold", int'(out), 2);

        load_nine();
        opcode = 3'd4; direction = 1; serial_in = 1; tick(2);
        check("shift_left_1", int'(out), 6'b010011);
        tick(1);
        check("shift_left_2", int'(out), 6'b100111);

        load_nine();
        opcode = 3'd5; direction = 0; tick(2);
        check("rot_right_1", int'(out), 6'b100100);
        tick(1);
        check("rot_right_2", int'(out), 6'b010010);

        red_op_A = 1; A = 3'b111; B = 3'b000; opcode = 3'd0; tick(2);
        check("red_and_a", int'(out), 1);
        opcode = 3'd1; tick(2);
        check("red_xor_a", int'(out), 1);
        red_op_A = 0; red_op_B = 1; B = 3'b011; tick(2);
        check("red_xor_b", int'(out), 0);
        red_op_A = 1; A = 3'b111; opcode = 3'd0; tick(2);
        check("red_prio_a", int'(out), 1);
        check("red_prio_b", int'(out_alt), 0);

        red_op_A = 0; red_op_B = 0; opcode = 3'd6; tick(2);
        check("inv_op6_out", int'(out), 0);
        check("inv_op6_leds", int'(leds), blink_hi);
        red_op_A = 1; opcode = 3'd3; tick(2);
        check("inv_red_mul_out", int'(out), 0);
        check("inv_red_mul_leds", int'(leds), blink_hi);
        red_op_A = 0; opcode = 3'd0; A = 3'd6; B = 3'd3; tick(2);
        check("and_6_3", int'(out), 2);
        check("leds_clear", int'(leds), 0);

        load_nine();
        opcode = 3'd5; direction = 1; tick(2);
        check("rot_left_1", int'(out), 6'b010010);
        #2 rst = 1;
        #1;
        check("async_rst_out", int'(out), 0);
        check("async_rst_leds", int'(leds), 0);
        check("async_rst_alt", int'(out_alt), 0);
        @(negedge clk);
        rst = 0;
        tick(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
